// File: rtl/asym_pack_pkg.sv
// Shared helpers and default geometry for the narrow-write / wide-read packing FIFO.
package asym_pack_pkg;

  localparam int unsigned DEF_IN_WIDTH    = 4;
  localparam int unsigned DEF_OUT_WIDTH   = 16;
  localparam int unsigned DEF_DEPTH_WORDS = 16;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/asym_ram_nw.sv
// Single-clock memory: narrow write port, wide registered read port.
// Narrow entry word_addr*RATIO+lane maps to lane bits of the wide word.
module asym_ram_nw
  import asym_pack_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = DEF_IN_WIDTH,
  parameter int unsigned OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic                                               i_clk,
  input  logic                                               i_we,
  input  logic [clog2(DEPTH_WORDS*(OUT_WIDTH/IN_WIDTH))-1:0] i_waddr,
  input  logic [IN_WIDTH-1:0]                                i_wdata,
  input  logic                                               i_re,
  input  logic [clog2(DEPTH_WORDS)-1:0]                      i_raddr,
  output logic [OUT_WIDTH-1:0]                               o_rdata
);

  localparam int unsigned RATIO        = OUT_WIDTH / IN_WIDTH;
  localparam int unsigned NARROW_DEPTH = DEPTH_WORDS * RATIO;
  localparam int unsigned NARROW_AW    = clog2(NARROW_DEPTH);

  logic [IN_WIDTH-1:0]  r_mem [NARROW_DEPTH];
  logic [OUT_WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) begin
      for (int k = 0; k < int'(RATIO); k++) begin
        r_q[k*IN_WIDTH +: IN_WIDTH] <= r_mem[NARROW_AW'(32'(i_raddr) * RATIO + 32'(k))];
      end
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/asym_pack_fifo.sv
// Packs RATIO narrow AXI-Stream elements (first one in the LSBs) into wide words,
// buffers them in an asymmetric RAM and drains them through a 2-entry output stage.
module asym_pack_fifo
  import asym_pack_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = DEF_IN_WIDTH,
  parameter int unsigned OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic [IN_WIDTH-1:0]              s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  output logic [OUT_WIDTH-1:0]             m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [$clog2(DEPTH_WORDS+2):0]   occupancy
);

  localparam int unsigned RATIO        = OUT_WIDTH / IN_WIDTH;
  localparam int unsigned LOG2_RATIO   = clog2(RATIO);
  localparam int unsigned NARROW_DEPTH = DEPTH_WORDS * RATIO;
  localparam int unsigned NARROW_AW    = clog2(NARROW_DEPTH);
  localparam int unsigned WORD_AW      = clog2(DEPTH_WORDS);
  localparam int unsigned NPW          = NARROW_AW + 1;
  localparam int unsigned WPW          = WORD_AW + 1;
  localparam int unsigned OCC_W        = clog2(DEPTH_WORDS + 2) + 1;
  localparam logic [NPW-1:0] LANE_MASK = NPW'(RATIO - 1);

  if ((OUT_WIDTH % IN_WIDTH) != 0 || !is_pow2(RATIO) ||
      !is_pow2(DEPTH_WORDS) || DEPTH_WORDS < 2) begin : g_bad_cfg
    $error("asym_pack_fifo: illegal IN_WIDTH/OUT_WIDTH/DEPTH_WORDS combination");
  end

  logic [NPW-1:0]       r_wr_ptr;
  logic [WPW-1:0]       r_rd_word;
  logic                 r_head_vld, r_skid_vld, r_pend;
  logic [OUT_WIDTH-1:0] r_head, r_skid;
  logic [OCC_W-1:0]     r_occ;

  logic [WPW-1:0]       w_wr_word, w_committed;
  logic                 w_full, w_s_ready, w_wr_fire, w_commit;
  logic [1:0]           w_stage_cnt;
  logic                 w_rd_issue, w_m_valid, w_pop;
  logic [OUT_WIDTH-1:0] w_ram_q, w_m_data;
  logic                 w_head_vld_n, w_skid_vld_n;
  logic [OUT_WIDTH-1:0] w_head_n, w_skid_n;
  logic [OCC_W-1:0]     w_occ_n;

  // A partially filled word already owns its slot, so fullness uses the word pointer.
  assign w_wr_word   = WPW'(r_wr_ptr >> LOG2_RATIO);
  assign w_committed = w_wr_word - r_rd_word;
  assign w_full      = (w_committed == WPW'(DEPTH_WORDS));
  assign w_s_ready   = ap_rst_n & ~w_full;
  assign w_wr_fire   = s_axis_tvalid & w_s_ready;
  assign w_commit    = w_wr_fire & ((r_wr_ptr & LANE_MASK) == LANE_MASK);

  // Read data in flight counts against the 2-entry output stage.
  assign w_stage_cnt = 2'(r_head_vld) + 2'(r_skid_vld) + 2'(r_pend);
  assign w_rd_issue  = (w_committed != '0) && (w_stage_cnt < 2'd2);

  // Fresh RAM data is presented directly when the stage is empty (2-cycle latency).
  assign w_m_valid = r_head_vld | r_pend;
  assign w_m_data  = r_head_vld ? r_head : (r_pend ? w_ram_q : '0);
  assign w_pop     = w_m_valid & m_axis_tready;

  asym_ram_nw #(
    .IN_WIDTH    (IN_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .i_clk   (ap_clk),
    .i_we    (w_wr_fire),
    .i_waddr (r_wr_ptr[NARROW_AW-1:0]),
    .i_wdata (s_axis_tdata),
    .i_re    (w_rd_issue),
    .i_raddr (r_rd_word[WORD_AW-1:0]),
    .o_rdata (w_ram_q)
  );

  // Output stage ordering is head, then skid, then the word arriving from RAM.
  always_comb begin
    w_head_vld_n = r_head_vld;
    w_head_n     = r_head;
    w_skid_vld_n = r_skid_vld;
    w_skid_n     = r_skid;
    if (w_pop) begin
      if (r_head_vld) begin
        if (r_skid_vld) begin
          w_head_n     = r_skid;
          w_skid_vld_n = r_pend;
          if (r_pend) w_skid_n = w_ram_q;
        end else begin
          w_head_vld_n = r_pend;
          w_skid_vld_n = 1'b0;
          if (r_pend) w_head_n = w_ram_q;
        end
      end else begin
        w_head_vld_n = 1'b0;
        w_skid_vld_n = 1'b0;
      end
    end else if (r_pend) begin
      if (!r_head_vld) begin
        w_head_vld_n = 1'b1;
        w_head_n     = w_ram_q;
      end else begin
        w_skid_vld_n = 1'b1;
        w_skid_n     = w_ram_q;
      end
    end
  end

  always_comb begin
    w_occ_n = r_occ;
    if (w_commit && !w_pop)      w_occ_n = r_occ + OCC_W'(1);
    else if (!w_commit && w_pop) w_occ_n = r_occ - OCC_W'(1);
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_word  <= '0;
      r_head_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_pend     <= 1'b0;
      r_head     <= '0;
      r_skid     <= '0;
      r_occ      <= '0;
    end else begin
      if (w_wr_fire)  r_wr_ptr  <= r_wr_ptr + NPW'(1);
      if (w_rd_issue) r_rd_word <= r_rd_word + WPW'(1);
      r_head_vld <= w_head_vld_n;
      r_head     <= w_head_n;
      r_skid_vld <= w_skid_vld_n;
      r_skid     <= w_skid_n;
      r_pend     <= w_rd_issue;
      r_occ      <= w_occ_n;
    end
  end

  assign s_axis_tready = w_s_ready;
  assign m_axis_tvalid = w_m_valid;
  assign m_axis_tdata  = w_m_data;
  assign occupancy     = r_occ;

endmodule

// File: tb/tb_asym_pack_fifo.sv
// Scoreboard bench for asym_pack_fifo: default 4->16 packer plus an 8->8 plain FIFO instance.
module tb_asym_pack_fifo;

  localparam int unsigned IW = 4;
  localparam int unsigned OW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned R  = OW / IW;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic [IW-1:0]            s_tdata;
  logic                     s_tvalid, s_tready;
  logic [OW-1:0]            m_tdata;
  logic                     m_tvalid, m_tready;
  logic [$clog2(DW+2):0]    occ;

  logic [7:0]               s2_tdata, m2_tdata;
  logic                     s2_tvalid, s2_tready, m2_tvalid, m2_tready;
  logic [$clog2(4+2):0]     occ2;

  asym_pack_fifo #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH_WORDS(DW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .occupancy(occ)
  );

  asym_pack_fifo #(.IN_WIDTH(8), .OUT_WIDTH(8), .DEPTH_WORDS(4)) dut2 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axis_tdata(s2_tdata), .s_axis_tvalid(s2_tvalid), .s_axis_tready(s2_tready),
    .m_axis_tdata(m2_tdata), .m_axis_tvalid(m2_tvalid), .m_axis_tready(m2_tready),
    .occupancy(occ2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pack elements into words in arrival order, queue them.
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] part;
  int            part_n = 0;
  int            words_out = 0;
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_data;

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      exp_q.delete();
      part       = '0;
      part_n     = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(m_tvalid), 32'd1);
        check("hold_data", 32'(m_tdata), 32'(prev_data));
      end
      if (s_tvalid && s_tready) begin
        part = part | (OW'(s_tdata) << (part_n * IW));
        part_n++;
        if (part_n == R) begin
          exp_q.push_back(part);
          part   = '0;
          part_n = 0;
        end
      end
      if (m_tvalid && m_tready) begin
        words_out++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got 0x%0h expected none", m_tdata);
        end else begin
          check("word", 32'(m_tdata), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end
  end

  // Reference for the RATIO=1 instance: plain FIFO order.
  logic [7:0] exp2_q[$];
  int         words2_out = 0;
  logic       prev2_stall = 1'b0;
  logic [7:0] prev2_data;

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      exp2_q.delete();
      prev2_stall = 1'b0;
    end else begin
      if (prev2_stall) begin
        check("hold2_valid", 32'(m2_tvalid), 32'd1);
        check("hold2_data", 32'(m2_tdata), 32'(prev2_data));
      end
      if (s2_tvalid && s2_tready) exp2_q.push_back(s2_tdata);
      if (m2_tvalid && m2_tready) begin
        words2_out++;
        if (exp2_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word2: got 0x%0h expected none", m2_tdata);
        end else begin
          check("word2", 32'(m2_tdata), 32'(exp2_q.pop_front()));
        end
      end
      prev2_stall = m2_tvalid && !m2_tready;
      prev2_data  = m2_tdata;
    end
  end

  task automatic push(input logic [IW-1:0] d, output int waits);
    s_tdata  = d;
    s_tvalid = 1'b1;
    waits    = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge ap_clk);
      if (s_tready) begin
        @(posedge ap_clk); #1;
        s_tvalid = 1'b0;
        return;
      end
      waits++;
      @(posedge ap_clk); #1;
    end
    s_tvalid = 1'b0;
    total++;
    bad++;
    $display("FAIL push_timeout: got tready=0 expected tready=1");
  endtask

  task automatic push2(input logic [7:0] d);
    s2_tdata  = d;
    s2_tvalid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge ap_clk);
      if (s2_tready) begin
        @(posedge ap_clk); #1;
        s2_tvalid = 1'b0;
        return;
      end
      @(posedge ap_clk); #1;
    end
    s2_tvalid = 1'b0;
    total++;
    bad++;
    $display("FAIL push2_timeout: got tready=0 expected tready=1");
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 5000; n++) begin
      @(negedge ap_clk); #1;
      if (exp_q.size() == 0 && occ == '0 && !m_tvalid &&
          exp2_q.size() == 0 && occ2 == '0 && !m2_tvalid) return;
    end
    total++;
    bad++;
    $display("FAIL %s: got not drained expected drained (q=%0d occ=%0d)", name, exp_q.size(), occ);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, stalls, acc, w0, sent;
    logic fire;
    s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
    s2_tvalid = 1'b0; s2_tdata = '0; m2_tready = 1'b1;

    // Reset state
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_tready", 32'(s_tready), 32'd0);
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata", 32'(m_tdata), 32'd0);
    check("rst_occ", 32'(occ), 32'd0);
    check("rst_tready2", 32'(s2_tready), 32'd0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("tready_after_rst", 32'(s_tready), 32'd1);
    check("tready2_after_rst", 32'(s2_tready), 32'd1);
    @(posedge ap_clk); #1;

    // Single word: latency and occupancy
    push(4'h1, w); push(4'h2, w); push(4'h3, w); push(4'h4, w);
    @(negedge ap_clk);
    check("t1_valid_e0", 32'(m_tvalid), 32'd0);
    check("t1_occ_e0", 32'(occ), 32'd1);
    @(negedge ap_clk);
    check("t1_valid_e1", 32'(m_tvalid), 32'd1);
    check("t1_data", 32'(m_tdata), 32'h4321);
    check("t1_occ_e1", 32'(occ), 32'd1);
    @(negedge ap_clk);
    check("t1_occ_e2", 32'(occ), 32'd0);
    check("t1_valid_e2", 32'(m_tvalid), 32'd0);
    @(posedge ap_clk); #1;

    // Continuous stream with free output
    w0 = words_out;
    stalls = 0;
    for (int i = 0; i < 64; i++) begin
      push(IW'(i % 16), w);
      stalls += w;
    end
    drain("t2_drain");
    check("t2_stalls", 32'(stalls), 32'd0);
    check("t2_words", 32'(words_out - w0), 32'd16);
    @(posedge ap_clk); #1;

    // Fill to full with output blocked
    m_tready = 1'b0;
    w0 = words_out;
    acc = 0;
    s_tvalid = 1'b1;
    s_tdata = IW'($urandom);
    for (int n = 0; n < 300; n++) begin
      @(negedge ap_clk);
      if (!s_tready) break;
      acc++;
      @(posedge ap_clk); #1;
      s_tdata = IW'($urandom);
    end
    check("t3_accepted", 32'(acc), 32'd72);
    check("t3_occ_full", 32'(occ), 32'd18);
    @(posedge ap_clk); #1;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    @(negedge ap_clk);
    @(negedge ap_clk);
    check("t3_tready_c1", 32'(s_tready), 32'd0);
    @(negedge ap_clk);
    check("t3_tready_c2", 32'(s_tready), 32'd1);
    drain("t3_drain");
    check("t3_words", 32'(words_out - w0), 32'd18);
    @(posedge ap_clk); #1;

    // Mid-word reset discards the partial word
    push(4'h7, w); push(4'h8, w); push(4'h9, w);
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    check("t4_tready_in_rst", 32'(s_tready), 32'd0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    w0 = words_out;
    push(4'hA, w); push(4'hB, w); push(4'hC, w); push(4'hD, w);
    @(negedge ap_clk);
    @(negedge ap_clk);
    check("t4_data", 32'(m_tdata), 32'hDCBA);
    drain("t4_drain");
    check("t4_words", 32'(words_out - w0), 32'd1);
    @(posedge ap_clk); #1;

    // Random valid/ready, many pointer wraps
    w0 = words_out;
    sent = 0;
    s_tvalid = 1'b0;
    while (sent < 10000) begin
      if (!s_tvalid && $urandom_range(1) == 1) begin
        s_tvalid = 1'b1;
        s_tdata  = IW'($urandom);
      end
      m_tready = ($urandom_range(1) == 1);
      @(negedge ap_clk);
      fire = s_tvalid && s_tready;
      @(posedge ap_clk); #1;
      if (fire) begin
        sent++;
        s_tvalid = 1'b0;
      end
    end
    m_tready = 1'b1;
    drain("t5_drain");
    check("t5_words", 32'(words_out - w0), 32'd2500);
    check("t5_occ", 32'(occ), 32'd0);
    @(posedge ap_clk); #1;

    // RATIO=1 instance: latency, capacity 4+2, order
    push2(8'h5A);
    @(negedge ap_clk);
    check("t6_valid_e0", 32'(m2_tvalid), 32'd0);
    @(negedge ap_clk);
    check("t6_valid_e1", 32'(m2_tvalid), 32'd1);
    check("t6_data", 32'(m2_tdata), 32'h5A);
    @(negedge ap_clk);
    check("t6_occ_e2", 32'(occ2), 32'd0);
    @(posedge ap_clk); #1;
    m2_tready = 1'b0;
    w0 = words2_out;
    acc = 0;
    s2_tvalid = 1'b1;
    s2_tdata = 8'($urandom);
    for (int n = 0; n < 100; n++) begin
      @(negedge ap_clk);
      if (!s2_tready) break;
      acc++;
      @(posedge ap_clk); #1;
      s2_tdata = 8'($urandom);
    end
    check("t6_accepted", 32'(acc), 32'd6);
    check("t6_occ_full", 32'(occ2), 32'd6);
    @(posedge ap_clk); #1;
    s2_tvalid = 1'b0;
    m2_tready = 1'b1;
    drain("t6_drain");
    check("t6_words", 32'(words2_out - w0), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
